// File: rtl/dpram_port0_arbiter_pkg.sv
// Shared types and helpers for the dual-port RAM port-0 arbiter.
// Optional feature macro: ARB_LOCK_EN (enables the LOCKED arbitration state).
package dpram_arb_pkg;

    // Arbitration FSM states; LOCKED is only reachable when ARB_LOCK_EN is defined.
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Cycles from a port-0 read grant to its response strobe.
    localparam int RD_LAT = 1;

    // Largest requester count supported by rr_pick.
    localparam int MAX_REQ = 8;

    // Reference round-robin pick: first valid bit at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n = MAX_REQ
    );
        logic [MAX_REQ-1:0] g;
        int                 idx;
        g = '0;
        for (int k = 0; k < n; k++) begin
            idx = (int'(ptr) + k) % n;
            if (g == '0 && valid[idx]) begin
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/dpram_port0_arbiter_if.sv
// Requester-side bus of the port-0 arbiter: request handshake plus read response.
// Optional feature macro: ARB_LOCK_EN (adds the req_lock hold request).
interface dpram_port0_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]            req_lock;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_lock,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_lock,
        output req_ready, rsp_valid, rsp_data
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
`endif
endinterface

// File: rtl/dpram_port0_arbiter_rr_grant_sel.sv
// Combinational round-robin selector: rotate so ptr is bit 0, take the lowest
// set bit, rotate back. Also returns the binary index of the winner.
module rr_grant_sel #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] valid_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    logic [2*N-1:0] rot_wide;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;
    logic [2*N-1:0] unrot_wide;

    assign rot_wide   = {valid_i, valid_i} >> ptr_i;
    assign rot        = rot_wide[N-1:0];
    assign pick       = rot & (~rot + 1'b1);
    assign unrot_wide = {pick, pick} << ptr_i;
    assign grant_o    = unrot_wide[2*N-1:N];
    assign any_o      = |valid_i;

    // One-hot to binary index of the winning requester.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                idx_o = idx_o | W'(i);
            end
        end
    end
endmodule

// File: rtl/dpram_port0_arbiter.sv
// Round-robin arbiter sharing port 0 of a dual-port RAM among NUM_REQ requesters,
// with port-1 read pass-through and same-cycle read/write collision flag.
// Optional feature macro: ARB_LOCK_EN (requester may hold the port via req_lock).
module dpram_port0_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    dpram_port0_arbiter_if.slave  bus,
    input  logic                  rd1_valid,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_rsp_valid,
    output logic [DATA_WIDTH-1:0] rd1_rsp_data,
    output logic                  rd1_collision,
    output logic                  ram_port_en_0,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr_in_0,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out_0,
    output logic                  ram_port_en_1,
    output logic [ADDR_WIDTH-1:0] ram_addr_in_1,
    input  logic [DATA_WIDTH-1:0] ram_data_out_1
);
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    cand_valid;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  grant_we;
    logic [IDX_W-1:0]      next_ptr;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic                  rd1_rsp_valid_q;
    logic                  rd1_collision_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef ARB_LOCK_EN
    arb_state_e       state_q;
    logic [IDX_W-1:0] lock_id_q;

    // While locked only the lock holder is eligible; nothing is granted in reset.
    always_comb begin
        cand_valid = bus.req_valid;
        if (state_q == LOCKED) begin
            cand_valid = bus.req_valid & (NUM_REQ'(1) << lock_id_q);
        end
        if (rst) begin
            cand_valid = '0;
        end
    end
`else
    assign cand_valid = rst ? '0 : bus.req_valid;
`endif

    rr_grant_sel #(.N(NUM_REQ), .W(IDX_W)) u_sel (
        .valid_i (cand_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign next_ptr      = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_we      = grant_any & bus.req_we[grant_idx];

    assign bus.req_ready = grant;
    assign ram_port_en_0 = grant_any;
    assign ram_wr_en     = grant_we;
    assign ram_addr_in_0 = grant_any ? addr_arr[grant_idx]  : '0;
    assign ram_data_in   = grant_any ? wdata_arr[grant_idx] : '0;

    assign ram_port_en_1 = rd1_valid;
    assign ram_addr_in_1 = rd1_addr;

`ifdef ARB_LOCK_EN
    // Arbitration FSM: the pointer only moves on a plain grant or on lock release.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            state_q   <= ARB;
            lock_id_q <= '0;
        end else if (grant_any) begin
            case (state_q)
                ARB: begin
                    if (bus.req_lock[grant_idx]) begin
                        state_q   <= LOCKED;
                        lock_id_q <= grant_idx;
                    end else begin
                        rr_ptr_q  <= next_ptr;
                    end
                end
                LOCKED: begin
                    if (!bus.req_lock[grant_idx]) begin
                        state_q  <= ARB;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end
`else
    // Round-robin pointer: one past the last winner, held when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (grant_any) begin
            rr_ptr_q <= next_ptr;
        end
    end
`endif

    // Response pipeline aligned with the RAM's one-cycle registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q     <= '0;
            rd1_rsp_valid_q <= 1'b0;
            rd1_collision_q <= 1'b0;
        end else begin
            rsp_valid_q     <= grant_we ? '0 : grant;
            rd1_rsp_valid_q <= rd1_valid;
            rd1_collision_q <= rd1_valid & grant_we & (rd1_addr == ram_addr_in_0);
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = (|rsp_valid_q) ? ram_data_out_0 : '0;
    assign rd1_rsp_valid = rd1_rsp_valid_q;
    assign rd1_rsp_data  = rd1_rsp_valid_q ? ram_data_out_1 : '0;
    assign rd1_collision = rd1_collision_q;
endmodule

// File: tb/tb_dpram_port0_arbiter.sv
// Testbench for dpram_port0_arbiter: vector table, directed reset/lock sequences,
// randomized traffic against a behavioural model. Lock sequence needs ARB_LOCK_EN.
module tb_dpram_port0_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tb_init = 1'b1;
    logic          rd1_valid = 1'b0;
    logic [AW-1:0] rd1_addr = '0;
    logic          rd1_rsp_valid, rd1_collision;
    logic [DW-1:0] rd1_rsp_data;
    logic          ram_port_en_0, ram_wr_en, ram_port_en_1;
    logic [AW-1:0] ram_addr_in_0, ram_addr_in_1;
    logic [DW-1:0] ram_data_in, ram_data_out_0, ram_data_out_1;
    logic [DW-1:0] env_mem [16];

    int checks = 0;
    int errors = 0;

    dpram_port0_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    dpram_port0_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if),
        .rd1_valid      (rd1_valid),
        .rd1_addr       (rd1_addr),
        .rd1_rsp_valid  (rd1_rsp_valid),
        .rd1_rsp_data   (rd1_rsp_data),
        .rd1_collision  (rd1_collision),
        .ram_port_en_0  (ram_port_en_0),
        .ram_wr_en      (ram_wr_en),
        .ram_addr_in_0  (ram_addr_in_0),
        .ram_data_in    (ram_data_in),
        .ram_data_out_0 (ram_data_out_0),
        .ram_port_en_1  (ram_port_en_1),
        .ram_addr_in_1  (ram_addr_in_1),
        .ram_data_out_1 (ram_data_out_1)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_byte(input int i);
        if (i < 4)       return 8'hA0 + 8'(i);
        else if (i == 7) return 8'h11;
        else             return 8'(i * 17);
    endfunction

    // External dual-port RAM: registered reads return the pre-write contents.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_byte(i);
        end else begin
            if (ram_port_en_0) begin
                if (ram_wr_en) env_mem[ram_addr_in_0] <= ram_data_in;
                ram_data_out_0 <= env_mem[ram_addr_in_0];
            end
            if (ram_port_en_1) ram_data_out_1 <= env_mem[ram_addr_in_1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] we, input logic [15:0] a,
                         input logic [31:0] wd, input logic r1v, input logic [3:0] r1a);
        bus_if.req_valid = v;
        bus_if.req_we    = we;
        bus_if.req_addr  = a;
        bus_if.req_wdata = wd;
        rd1_valid        = r1v;
        rd1_addr         = r1a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        rd1v;
        logic [3:0]  rd1a;
        logic [3:0]  e_ready;
        logic [3:0]  e_rsp;
        logic [7:0]  e_data;
        logic        e_rd1v;
        logic [7:0]  e_rd1d;
        logic        e_coll;
    } vec_t;

    vec_t tbl [19];

    // Model state for the randomized phase.
    logic [DW-1:0] shadow [16];
    int            m_ptr;
    logic [3:0]    exp_rsp_v;
    logic [7:0]    exp_rsp_d;
    logic          exp_rd1_v, exp_coll;
    logic [7:0]    exp_rd1_d;

    initial begin
        logic [3:0] exp_addr;
        logic       exp_we;
        logic       v [N];
        logic       wv [N];
        logic [3:0] ra [N];
        logic [7:0] rw [N];
        logic       pend [N];
        logic       r1v;
        logic [3:0] r1a;
        int         g;
        int         idx;

        //          valid  we    addr      wdata         r1v r1a  ready rsp  data   rd1v rd1d  coll
        tbl[0]  = '{4'h0, 4'h0, 16'h0000, 32'h00000000, 0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 8'h00, 0};
        tbl[1]  = '{4'hF, 4'h0, 16'h3210, 32'h00000000, 0, 4'h0, 4'h1, 4'h0, 8'h00, 0, 8'h00, 0};
        tbl[2]  = '{4'hE, 4'h0, 16'h3210, 32'h00000000, 0, 4'h0, 4'h2, 4'h1, 8'hA0, 0, 8'h00, 0};
        tbl[3]  = '{4'hC, 4'h0, 16'h3210, 32'h00000000, 0, 4'h0, 4'h4, 4'h2, 8'hA1, 0, 8'h00, 0};
        tbl[4]  = '{4'h8, 4'h0, 16'h3210, 32'h00000000, 0, 4'h0, 4'h8, 4'h4, 8'hA2, 0, 8'h00, 0};
        tbl[5]  = '{4'h0, 4'h0, 16'h0000, 32'h00000000, 0, 4'h0, 4'h0, 4'h8, 8'hA3, 0, 8'h00, 0};
        tbl[6]  = '{4'h1, 4'h1, 16'h0005, 32'h0000003C, 0, 4'h0, 4'h1, 4'h0, 8'h00, 0, 8'h00, 0};
        tbl[7]  = '{4'h2, 4'h0, 16'h0050, 32'h00000000, 0, 4'h0, 4'h2, 4'h0, 8'h00, 0, 8'h00, 0};
        tbl[8]  = '{4'h0, 4'h0, 16'h0000, 32'h00000000, 0, 4'h0, 4'h0, 4'h2, 8'h3C, 0, 8'h00, 0};
        tbl[9]  = '{4'h4, 4'h0, 16'h0200, 32'h00000000, 0, 4'h0, 4'h4, 4'h0, 8'h00, 0, 8'h00, 0};
        tbl[10] = '{4'h4, 4'h0, 16'h0200, 32'h00000000, 0, 4'h0, 4'h4, 4'h4, 8'hA2, 0, 8'h00, 0};
        tbl[11] = '{4'h4, 4'h0, 16'h0200, 32'h00000000, 0, 4'h0, 4'h4, 4'h4, 8'hA2, 0, 8'h00, 0};
        tbl[12] = '{4'h9, 4'h0, 16'h1000, 32'h00000000, 0, 4'h0, 4'h8, 4'h4, 8'hA2, 0, 8'h00, 0};
        tbl[13] = '{4'h1, 4'h0, 16'h0000, 32'h00000000, 0, 4'h0, 4'h1, 4'h8, 8'hA1, 0, 8'h00, 0};
        tbl[14] = '{4'h0, 4'h0, 16'h0000, 32'h00000000, 0, 4'h0, 4'h0, 4'h1, 8'hA0, 0, 8'h00, 0};
        tbl[15] = '{4'h1, 4'h1, 16'h0007, 32'h00000055, 1, 4'h7, 4'h1, 4'h0, 8'h00, 0, 8'h00, 0};
        tbl[16] = '{4'h0, 4'h0, 16'h0000, 32'h00000000, 1, 4'h7, 4'h0, 4'h0, 8'h00, 1, 8'h11, 1};
        tbl[17] = '{4'h0, 4'h0, 16'h0000, 32'h00000000, 0, 4'h0, 4'h0, 4'h0, 8'h00, 1, 8'h55, 0};
        tbl[18] = '{4'h0, 4'h0, 16'h0000, 32'h00000000, 0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 8'h00, 0};

        drive(4'h0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0);
`ifdef ARB_LOCK_EN
        bus_if.req_lock = '0;
`endif
        repeat (3) step();
        rst = 1'b0;
        tb_init = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int r = 0; r < 19; r++) begin
            drive(tbl[r].valid, tbl[r].we, tbl[r].addr, tbl[r].wdata, tbl[r].rd1v, tbl[r].rd1a);
            exp_we   = |(tbl[r].e_ready & tbl[r].we);
            exp_addr = '0;
            for (int i = 0; i < N; i++) if (tbl[r].e_ready[i]) exp_addr = tbl[r].addr[i*4 +: 4];
            @(negedge clk);
            $display("row %0d valid=%h ready=%h rsp_valid=%h rsp_data=%h rd1=%b/%h coll=%b",
                     r, tbl[r].valid, bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_data,
                     rd1_rsp_valid, rd1_rsp_data, rd1_collision);
            chk($sformatf("r%0d req_ready", r), 32'(bus_if.req_ready), 32'(tbl[r].e_ready));
            chk($sformatf("r%0d port_en_0", r), 32'(ram_port_en_0), 32'(|tbl[r].e_ready));
            chk($sformatf("r%0d wr_en", r), 32'(ram_wr_en), 32'(exp_we));
            if (tbl[r].e_ready != 0)
                chk($sformatf("r%0d addr_in_0", r), 32'(ram_addr_in_0), 32'(exp_addr));
            chk($sformatf("r%0d rsp_valid", r), 32'(bus_if.rsp_valid), 32'(tbl[r].e_rsp));
            if (tbl[r].e_rsp != 0)
                chk($sformatf("r%0d rsp_data", r), 32'(bus_if.rsp_data), 32'(tbl[r].e_data));
            chk($sformatf("r%0d rd1_rsp_valid", r), 32'(rd1_rsp_valid), 32'(tbl[r].e_rd1v));
            if (tbl[r].e_rd1v)
                chk($sformatf("r%0d rd1_rsp_data", r), 32'(rd1_rsp_data), 32'(tbl[r].e_rd1d));
            chk($sformatf("r%0d rd1_collision", r), 32'(rd1_collision), 32'(tbl[r].e_coll));
            step();
        end

        // ---------------- reset in the middle of traffic (pointer is 1 here) ----------------
        drive(4'h2, 4'h0, 16'h3210, 32'h0, 1'b0, 4'h0);
        @(negedge clk);
        $display("rst seq 0 ready=%h", bus_if.req_ready);
        chk("rst0 req_ready", 32'(bus_if.req_ready), 32'h2);
        step();
        rst = 1'b1;
        drive(4'hF, 4'h0, 16'h3210, 32'h0, 1'b0, 4'h0);
        @(negedge clk);
        $display("rst seq 1 ready=%h rsp_valid=%h", bus_if.req_ready, bus_if.rsp_valid);
        chk("rst1 req_ready", 32'(bus_if.req_ready), 32'h0);
        chk("rst1 port_en_0", 32'(ram_port_en_0), 32'h0);
        chk("rst1 rsp_valid", 32'(bus_if.rsp_valid), 32'h2);
        chk("rst1 rsp_data", 32'(bus_if.rsp_data), 32'hA1);
        step();
        rst = 1'b0;
        @(negedge clk);
        $display("rst seq 2 ready=%h rsp_valid=%h", bus_if.req_ready, bus_if.rsp_valid);
        chk("rst2 rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
        chk("rst2 req_ready", 32'(bus_if.req_ready), 32'h1);
        step();
        drive(4'h0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0);
        @(negedge clk);
        $display("rst seq 3 rsp_valid=%h rsp_data=%h", bus_if.rsp_valid, bus_if.rsp_data);
        chk("rst3 rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
        chk("rst3 rsp_data", 32'(bus_if.rsp_data), 32'hA0);
        step();

`ifdef ARB_LOCK_EN
        // ---------------- lock sequence (pointer is 1 here) ----------------
        drive(4'h3, 4'h2, 16'h0090, 32'h00006100, 1'b0, 4'h0);
        bus_if.req_lock = 4'h2;
        @(negedge clk);
        $display("lock 0 ready=%h", bus_if.req_ready);
        chk("lock0 req_ready", 32'(bus_if.req_ready), 32'h2);
        step();
        bus_if.req_wdata = 32'h00006200;
        @(negedge clk);
        $display("lock 1 ready=%h", bus_if.req_ready);
        chk("lock1 req_ready", 32'(bus_if.req_ready), 32'h2);
        step();
        drive(4'h1, 4'h0, 16'h0090, 32'h0, 1'b0, 4'h0);
        bus_if.req_lock = 4'h0;
        @(negedge clk);
        $display("lock 2 ready=%h", bus_if.req_ready);
        chk("lock2 holder idle", 32'(bus_if.req_ready), 32'h0);
        step();
        drive(4'h3, 4'h2, 16'h0090, 32'h00006300, 1'b0, 4'h0);
        @(negedge clk);
        $display("lock 3 ready=%h", bus_if.req_ready);
        chk("lock3 unlock write", 32'(bus_if.req_ready), 32'h2);
        step();
        drive(4'h1, 4'h0, 16'h0090, 32'h0, 1'b0, 4'h0);
        @(negedge clk);
        $display("lock 4 ready=%h", bus_if.req_ready);
        chk("lock4 req0 granted", 32'(bus_if.req_ready), 32'h1);
        step();
        drive(4'h0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0);
        @(negedge clk);
        $display("lock 5 rsp_valid=%h rsp_data=%h", bus_if.rsp_valid, bus_if.rsp_data);
        chk("lock5 rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
        chk("lock5 rsp_data", 32'(bus_if.rsp_data), 32'hA0);
        step();
`endif

        // ---------------- randomized traffic vs behavioural model ----------------
        drive(4'h0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = env_mem[i];
        m_ptr = 0;
        exp_rsp_v = '0; exp_rsp_d = '0;
        exp_rd1_v = 1'b0; exp_rd1_d = '0; exp_coll = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; v[i] = 1'b0; wv[i] = 1'b0; ra[i] = '0; rw[i] = '0;
        end

        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!(pend[i] && $urandom_range(0, 4) != 0)) begin
                    v[i]  = ($urandom_range(0, 9) < 5);
                    wv[i] = 1'($urandom_range(0, 1));
                    ra[i] = 4'($urandom_range(0, 7));
                    rw[i] = 8'($urandom_range(0, 255));
                end
                bus_if.req_valid[i]         = v[i];
                bus_if.req_we[i]            = wv[i];
                bus_if.req_addr[i*AW +: AW] = ra[i];
                bus_if.req_wdata[i*DW +: DW] = rw[i];
            end
            r1v = ($urandom_range(0, 1) == 1);
            r1a = 4'($urandom_range(0, 7));
            rd1_valid = r1v;
            rd1_addr  = r1a;

            // Winner: first valid requester starting at the pointer, wrapping around.
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end

            @(negedge clk);
            chk($sformatf("rnd%0d req_ready", cyc), 32'(bus_if.req_ready),
                (g >= 0) ? (32'h1 << g) : 32'h0);
            chk($sformatf("rnd%0d port_en_0", cyc), 32'(ram_port_en_0), 32'(g >= 0));
            if (g >= 0) begin
                chk($sformatf("rnd%0d wr_en", cyc), 32'(ram_wr_en), 32'(wv[g]));
                chk($sformatf("rnd%0d addr_in_0", cyc), 32'(ram_addr_in_0), 32'(ra[g]));
                if (wv[g]) chk($sformatf("rnd%0d data_in", cyc), 32'(ram_data_in), 32'(rw[g]));
                $display("rnd %0d grant %0d %s addr=%h data=%h", cyc, g, wv[g] ? "wr" : "rd",
                         ra[g], wv[g] ? rw[g] : shadow[ra[g]]);
            end
            chk($sformatf("rnd%0d rsp_valid", cyc), 32'(bus_if.rsp_valid), 32'(exp_rsp_v));
            if (exp_rsp_v != 0)
                chk($sformatf("rnd%0d rsp_data", cyc), 32'(bus_if.rsp_data), 32'(exp_rsp_d));
            chk($sformatf("rnd%0d rd1_rsp_valid", cyc), 32'(rd1_rsp_valid), 32'(exp_rd1_v));
            if (exp_rd1_v)
                chk($sformatf("rnd%0d rd1_rsp_data", cyc), 32'(rd1_rsp_data), 32'(exp_rd1_d));
            chk($sformatf("rnd%0d rd1_collision", cyc), 32'(rd1_collision), 32'(exp_coll));

            // Advance the model by one cycle.
            exp_rd1_v = r1v;
            exp_rd1_d = shadow[r1a];
            exp_coll  = r1v && (g >= 0) && wv[g] && (ra[g] == r1a);
            exp_rsp_v = '0;
            if (g >= 0) begin
                if (wv[g]) begin
                    shadow[ra[g]] = rw[g];
                end else begin
                    exp_rsp_v = 4'(1 << g);
                    exp_rsp_d = shadow[ra[g]];
                end
                m_ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) pend[i] = v[i] && (i != g);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dpram_port0_arbiter.md
Name: dpram_port0_arbiter

Overview:
- Round-robin arbiter that shares port 0 (read/write) of the team's dual-port RAM among NUM_REQ requesters using a valid/ready handshake.
- Routes the 1-cycle registered read data back to the granted requester with a one-hot response strobe.
- Passes a dedicated read client through to port 1 and flags same-cycle read/write address collisions.
- Sits between the DMA/CPU-side masters and the RAM instance; the RAM is external to this block.

Parameters:
- NUM_REQ, 4, number of port-0 requesters (2..8).
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width.
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot grant; the transfer happens when valid&ready.
- rsp_valid  out  NUM_REQ  one-hot read-data strobe.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters.
- rd1_valid  in  1  port-1 read request.
- rd1_addr  in  ADDR_WIDTH  port-1 address.
- rd1_rsp_valid  out  1  port-1 data strobe.
- rd1_rsp_data  out  DATA_WIDTH  port-1 read data.
- rd1_collision  out  1  port-1 read hit the address written on port 0 in the same cycle.
- ram_port_en_0, ram_wr_en, ram_addr_in_0, ram_data_in  out  1/1/ADDR_WIDTH/DATA_WIDTH  drive RAM port 0.
- ram_data_out_0  in  DATA_WIDTH  RAM port-0 read data.
- ram_port_en_1, ram_addr_in_1  out  1/ADDR_WIDTH  drive RAM port 1.
- ram_data_out_1  in  DATA_WIDTH  RAM port-1 read data.
- req_lock  in  NUM_REQ  hold request; present only with ARB_LOCK_EN.

Behaviour:
- Reset clears all registered state; every registered output reads 0 until the first post-reset request:
  - rr_ptr = 0, rsp_valid = 0, rsp_data = 0, rd1_rsp_valid = 0, rd1_collision = 0, FSM = ARB.
- Grant is combinational from req_valid and the registered rr_ptr:
  - Search starts at index rr_ptr and wraps NUM_REQ-1 -> 0.
  - The first valid requester found gets req_ready.
  - At most one req_ready bit is high; req_ready = 0 when no request is valid or during rst.
- Port-0 drive is combinational from the granted requester: ram_port_en_0 = |grant, ram_wr_en = that requester's we, plus its address and data. With no grant, en = 0 and wr_en = 0.
- After a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Read latency is 1 cycle. A read granted in cycle N gives rsp_valid[g] = 1 in cycle N+1, with rsp_data = ram_data_out_0 in N+1. Writes produce no response.
- Back-to-back grants are allowed every cycle; no bubble between requesters.
- Requesters hold addr/we/wdata stable while valid and not ready. Dropping valid before ready is legal and loses nothing.
- Port 1 is a pure pass-through: ram_port_en_1 = rd1_valid, ram_addr_in_1 = rd1_addr. It is never stalled.
- rd1_rsp_valid is rd1_valid delayed one cycle; rd1_rsp_data = ram_data_out_1.
- Collision: rd1_valid & port-0 write & equal addresses in cycle N gives rd1_collision = 1 in N+1, aligned with rd1_rsp_valid. The data is the pre-write (old) value.
- rst asserted mid-transfer: any response due the next cycle is suppressed (rsp_valid = 0), and rr_ptr returns to 0.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined, the req_lock port exists and the FSM has two states:
  - ARB: normal round-robin.
  - ARB -> LOCKED when the granted requester g has req_lock[g] = 1; the block stores lock_id = g.
  - LOCKED: only requester lock_id can be granted; others wait even if lock_id has valid low.
  - LOCKED -> ARB on the first granted transfer from lock_id with req_lock[lock_id] = 0.
  - rr_ptr advances only when leaving LOCKED, to lock_id+1.
  - rst forces ARB.
- When undefined: no req_lock port, no FSM, and the FSM register is optimised away.

Decomposition:
- Package dpram_arb_pkg holds:
  - the FSM state typedef (ARB, LOCKED);
  - a localparam for read latency RD_LAT = 1;
  - the function rr_pick(valid, ptr) returning a one-hot grant.
- One sub-module, rr_grant_sel, is natural: combinational rotate, priority pick and unrotate, reusable by other arbiters.
- The RAM stays outside the block and is connected by the integrating top.

Test Plan:
- rst 1 then 0, no requests -> req_ready = 0, rsp_valid = 0, ram_port_en_0 = 0, and rr_ptr = 0.
- NUM_REQ=4, all four valid, reads of addr 0..3 pre-filled with 0xA0..0xA3 -> grants 0,1,2,3 on consecutive cycles. rsp_valid one-hot one cycle later, carrying 0xA0..0xA3 in order.
- Req0 write addr 5 = 0x3C in cycle N, req1 read addr 5 in N+1 -> rsp_valid[1] in N+2 with rsp_data = 0x3C.
- Port-0 write addr 7 = 0x55 (old 0x11) plus rd1 read addr 7 in the same cycle -> rd1_rsp_data = 0x11 and rd1_collision = 1 next cycle. Next-cycle rd1 read returns 0x55.
- Only req2 valid for 3 cycles, then req0 and req3 valid -> req2 gets 3 grants, then req3 is granted before req0 (rr_ptr = 3).
- ARB_LOCK_EN: req1 locks for 3 writes while req0 is valid -> req0 is stalled until req1's unlocked write completes, then req0 is granted.
